// File: rtl/game_pkg.sv
// Shared definitions for the bird-shoot scoring block: FSM encoding,
// default game constants and the double-dabble digit adjust.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_EVAL      = 2'd2,
    ST_GAME_OVER = 2'd3
  } game_state_t;

  localparam int DEF_BIRDS_PER_ROUND = 10;
  localparam int DEF_PASS_MIN        = 6;
  localparam int DEF_SCORE_W         = 14;
  localparam int DEF_HIT_POINTS      = 50;
  localparam int DEF_ESCAPE_PENALTY  = 10;
  localparam int DEF_ROUND_W         = 4;
  localparam int DEF_BCD_DIGITS      = 4;

  function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
    if (digit >= 4'd5) begin
      bcd_adjust = digit + 4'd3;
    end else begin
      bcd_adjust = digit;
    end
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, BIN_W cycles per
// conversion; a new load restarts it and bcd holds until a conversion ends.
module bin2bcd_seq
  import game_pkg::*;
#(
  parameter int BIN_W  = DEF_SCORE_W,
  parameter int DIGITS = DEF_BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    shift_r;
  logic [4*DIGITS-1:0] work_r;
  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] adj_s;
  logic [4*DIGITS-1:0] step_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r;
  logic                done_r;

  // One shift-and-adjust step; digits above DIGITS fall off the top.
  always_comb begin
    adj_s = {(4*DIGITS){1'b0}};
    for (int d = 0; d < DIGITS; d++) begin
      adj_s[4*d +: 4] = bcd_adjust(work_r[4*d +: 4]);
    end
    step_s = {adj_s[4*DIGITS-2:0], shift_r[BIN_W-1]};
  end

  // Conversion sequencer; bcd and done are published on the final step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_r <= {BIN_W{1'b0}};
      work_r  <= {(4*DIGITS){1'b0}};
      bcd_r   <= {(4*DIGITS){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b1;
    end else if (load) begin
      shift_r <= bin;
      work_r  <= {(4*DIGITS){1'b0}};
      cnt_r   <= CNT_W'(BIN_W);
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else if (busy_r) begin
      shift_r <= {shift_r[BIN_W-2:0], 1'b0};
      work_r  <= step_s;
      cnt_r   <= cnt_r - CNT_W'(1);
      if (cnt_r == CNT_W'(1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
        bcd_r  <= step_s;
      end
    end
  end

  assign bcd  = bcd_r;
  assign done = done_r;

endmodule

// File: rtl/score_round_ctrl.sv
// Round/score controller: tracks bird outcomes per round, keeps a saturating
// score, evaluates each round and keeps a BCD copy of the score.
module score_round_ctrl
  import game_pkg::*;
#(
  parameter int BIRDS_PER_ROUND = DEF_BIRDS_PER_ROUND,
  parameter int PASS_MIN        = DEF_PASS_MIN,
  parameter int SCORE_W         = DEF_SCORE_W,
  parameter int HIT_POINTS      = DEF_HIT_POINTS,
  parameter int ESCAPE_PENALTY  = DEF_ESCAPE_PENALTY,
  parameter int ROUND_W         = DEF_ROUND_W,
  parameter int BCD_DIGITS      = DEF_BCD_DIGITS
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   start,
  input  logic                                   hit_evt,
  input  logic                                   escape_evt,
  output logic [BIRDS_PER_ROUND-1:0]             bird_mask,
  output logic [$clog2(BIRDS_PER_ROUND+1)-1:0]   hits,
  output logic [$clog2(BIRDS_PER_ROUND+1)-1:0]   misses,
  output logic [ROUND_W-1:0]                     round,
  output logic [SCORE_W-1:0]                     score,
  output logic [4*BCD_DIGITS-1:0]                score_bcd,
  output logic                                   bcd_valid,
  output logic                                   round_done,
  output logic                                   game_over,
  output logic                                   playing
);

  localparam int CNT_W = $clog2(BIRDS_PER_ROUND + 1);
  localparam logic [SCORE_W:0]           SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W:0]           HIT_PTS   = (SCORE_W+1)'(HIT_POINTS);
  localparam logic [SCORE_W-1:0]         ESC_PTS   = SCORE_W'(ESCAPE_PENALTY);
  localparam logic [CNT_W:0]             BIRDS_C   = (CNT_W+1)'(BIRDS_PER_ROUND);
  localparam logic [CNT_W-1:0]           PASS_C    = CNT_W'(PASS_MIN);
  localparam logic [BIRDS_PER_ROUND-1:0] ONE_B     = {{(BIRDS_PER_ROUND-1){1'b0}}, 1'b1};

  game_state_t                state_r, state_nxt;
  logic [SCORE_W-1:0]         score_r, score_nxt;
  logic [ROUND_W-1:0]         round_r, round_nxt;
  logic [CNT_W-1:0]           hits_r, hits_nxt;
  logic [CNT_W-1:0]           misses_r, misses_nxt;
  logic [BIRDS_PER_ROUND-1:0] mask_r, mask_nxt;
  logic                       round_done_r, round_done_nxt;
  logic                       playing_r, game_over_r;

  logic [SCORE_W:0]           add_s;
  logic [SCORE_W-1:0]         score_add_s, score_sub_s;
  logic [CNT_W:0]             filled_s;
  logic [CNT_W-1:0]           slot_s;
  logic [BIRDS_PER_ROUND-1:0] mask_clr_s;
  logic                       conv_load_s;

  // Saturating score arithmetic and the bird slot of the current event.
  always_comb begin
    add_s = {1'b0, score_r} + HIT_PTS;
    if (add_s > SCORE_MAX) begin
      score_add_s = SCORE_MAX[SCORE_W-1:0];
    end else begin
      score_add_s = add_s[SCORE_W-1:0];
    end
    if (score_r < ESC_PTS) begin
      score_sub_s = {SCORE_W{1'b0}};
    end else begin
      score_sub_s = score_r - ESC_PTS;
    end
    filled_s   = {1'b0, hits_r} + {1'b0, misses_r} + (CNT_W+1)'(1);
    slot_s     = hits_r + misses_r;
    mask_clr_s = mask_r & ~(ONE_B << slot_s);
  end

  // Next-state and datapath updates; a hit wins over a simultaneous escape.
  always_comb begin
    state_nxt      = state_r;
    score_nxt      = score_r;
    round_nxt      = round_r;
    hits_nxt       = hits_r;
    misses_nxt     = misses_r;
    mask_nxt       = mask_r;
    round_done_nxt = 1'b0;
    case (state_r)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          state_nxt  = ST_PLAY;
          score_nxt  = {SCORE_W{1'b0}};
          round_nxt  = {ROUND_W{1'b0}};
          hits_nxt   = {CNT_W{1'b0}};
          misses_nxt = {CNT_W{1'b0}};
          mask_nxt   = {BIRDS_PER_ROUND{1'b1}};
        end else begin
          state_nxt = state_r;
        end
      end
      ST_PLAY: begin
        if (hit_evt) begin
          hits_nxt  = hits_r + CNT_W'(1);
          mask_nxt  = mask_clr_s;
          score_nxt = score_add_s;
          state_nxt = (filled_s == BIRDS_C) ? ST_EVAL : ST_PLAY;
        end else if (escape_evt) begin
          misses_nxt = misses_r + CNT_W'(1);
          score_nxt  = score_sub_s;
          state_nxt  = (filled_s == BIRDS_C) ? ST_EVAL : ST_PLAY;
        end else begin
          state_nxt = ST_PLAY;
        end
      end
      ST_EVAL: begin
        if (hits_r >= PASS_C) begin
          round_nxt      = round_r + ROUND_W'(1);
          hits_nxt       = {CNT_W{1'b0}};
          misses_nxt     = {CNT_W{1'b0}};
          mask_nxt       = {BIRDS_PER_ROUND{1'b1}};
          round_done_nxt = 1'b1;
          state_nxt      = ST_PLAY;
        end else begin
          state_nxt = ST_GAME_OVER;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      score_r      <= {SCORE_W{1'b0}};
      round_r      <= {ROUND_W{1'b0}};
      hits_r       <= {CNT_W{1'b0}};
      misses_r     <= {CNT_W{1'b0}};
      mask_r       <= {BIRDS_PER_ROUND{1'b1}};
      round_done_r <= 1'b0;
      playing_r    <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      score_r      <= score_nxt;
      round_r      <= round_nxt;
      hits_r       <= hits_nxt;
      misses_r     <= misses_nxt;
      mask_r       <= mask_nxt;
      round_done_r <= round_done_nxt;
      playing_r    <= (state_nxt == ST_PLAY) || (state_nxt == ST_EVAL);
      game_over_r  <= (state_nxt == ST_GAME_OVER);
    end
  end

  // Loading with the incoming score makes bcd_valid fall as the new score appears.
  assign conv_load_s = (score_nxt != score_r);

  bin2bcd_seq #(
    .BIN_W  (SCORE_W),
    .DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .resetn (resetn),
    .load   (conv_load_s),
    .bin    (score_nxt),
    .bcd    (score_bcd),
    .done   (bcd_valid)
  );

  assign bird_mask  = mask_r;
  assign hits       = hits_r;
  assign misses     = misses_r;
  assign round      = round_r;
  assign score      = score_r;
  assign round_done = round_done_r;
  assign playing    = playing_r;
  assign game_over  = game_over_r;

endmodule
